// File: rtl/timer_pkg.sv
// Shared types for the timer controller: state codes and width helpers.
// Used by timer_controller to size its prescaler and alarm counter.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: 2-FF synchronizer plus registered rising-edge pulse.
// Ports: clk, reset (async active-low), btn (raw), pulse (one cycle per press).
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/timer_controller.sv
// Run/pause/done sequencer for the timer: button events, count tick, alarm.
// Ports: clk, reset, buttons, count_up, counter flags in; counter commands, alarm, state out.
module timer_controller
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       delete,
    input  logic       inc_sec_btn,
    input  logic       inc_min_btn,
    input  logic       count_up,
    input  logic       counter_zero,
    input  logic       counter_finish,
    output logic       enable_counter,
    output logic       forward,
    output logic       clear_counter,
    output logic       inc_seconds,
    output logic       inc_minutes,
    output logic       alarm,
    output logic       alarm_blink,
    output logic [1:0] state
);

    localparam int PW = width_for(TICK_DIV);
    localparam int AW = width_for(ALARM_TICKS + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ACNT_MAX = AW'(ALARM_TICKS);

    logic ev_start;
    logic ev_stop;
    logic ev_del;
    logic ev_imin;
    logic ev_isec;

    btn_edge u_start (.clk(clk), .reset(reset), .btn(start),       .pulse(ev_start));
    btn_edge u_stop  (.clk(clk), .reset(reset), .btn(stop),        .pulse(ev_stop));
    btn_edge u_del   (.clk(clk), .reset(reset), .btn(delete),      .pulse(ev_del));
    btn_edge u_imin  (.clk(clk), .reset(reset), .btn(inc_min_btn), .pulse(ev_imin));
    btn_edge u_isec  (.clk(clk), .reset(reset), .btn(inc_sec_btn), .pulse(ev_isec));

    // Only the highest-priority event of a cycle survives.
    logic do_del;
    logic do_stop;
    logic do_start;
    logic do_imin;
    logic do_isec;

    assign do_del   = ev_del;
    assign do_stop  = ev_stop & ~ev_del;
    assign do_start = ev_start & ~ev_stop & ~ev_del;
    assign do_imin  = ev_imin & ~ev_start & ~ev_stop & ~ev_del;
    assign do_isec  = ev_isec & ~ev_imin & ~ev_start & ~ev_stop & ~ev_del;

    state_t        st;
    logic [PW-1:0] pre;
    logic [AW-1:0] acnt;
    logic          tick;
    logic [PW-1:0] pre_nx;

    assign tick   = (pre == PRE_MAX);
    assign pre_nx = tick ? '0 : pre + PW'(1);
    assign state  = st;

    // The prescaler only advances on cycles that actually count time;
    // stop/finish/exit cycles leave it where it was.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st             <= ST_IDLE;
            forward        <= 1'b1;
            pre            <= '0;
            acnt           <= '0;
            enable_counter <= 1'b0;
            clear_counter  <= 1'b0;
            inc_seconds    <= 1'b0;
            inc_minutes    <= 1'b0;
            alarm          <= 1'b0;
            alarm_blink    <= 1'b0;
        end else begin
            enable_counter <= 1'b0;
            clear_counter  <= 1'b0;
            inc_seconds    <= 1'b0;
            inc_minutes    <= 1'b0;
            unique case (st)
                ST_IDLE: begin
                    if (do_del) begin
                        clear_counter <= 1'b1;
                    end else if (do_imin) begin
                        inc_minutes <= 1'b1;
                    end else if (do_isec) begin
                        inc_seconds <= 1'b1;
                    end else if (do_start && (count_up || !counter_zero)) begin
                        st      <= ST_RUN;
                        forward <= count_up;
                        pre     <= '0;
                    end
                end
                ST_RUN: begin
                    if (do_del) begin
                        clear_counter <= 1'b1;
                        st            <= ST_IDLE;
                    end else if (do_stop) begin
                        st <= ST_PAUSE;
                    end else if (counter_finish) begin
                        st          <= ST_DONE;
                        alarm       <= 1'b1;
                        alarm_blink <= 1'b0;
                        acnt        <= '0;
                    end else begin
                        pre            <= pre_nx;
                        enable_counter <= tick;
                    end
                end
                ST_PAUSE: begin
                    if (do_del) begin
                        clear_counter <= 1'b1;
                        st            <= ST_IDLE;
                    end else if (do_start) begin
                        st <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (do_del || do_stop || do_start) begin
                        clear_counter <= do_del;
                        st            <= ST_IDLE;
                        alarm         <= 1'b0;
                        alarm_blink   <= 1'b0;
                    end else if (acnt == ACNT_MAX) begin
                        st          <= ST_IDLE;
                        alarm       <= 1'b0;
                        alarm_blink <= 1'b0;
                    end else begin
                        pre <= pre_nx;
                        if (tick) begin
                            alarm_blink <= ~alarm_blink;
                            acnt        <= acnt + AW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
